// File: rtl/dbg_dma_pkg.sv
// Shared definitions for the debug DMA trace path.
// Register offsets, ring bounds and Wishbone slave states.
package dbg_dma_pkg;

   localparam logic [3:0] REG_STATUS  = 4'h0;
   localparam logic [3:0] REG_HEAD    = 4'h4;
   localparam logic [3:0] REG_POP     = 4'h8;
   localparam logic [3:0] REG_RELEASE = 4'hC;

   localparam logic [31:0] MEM_MIN_ADDR = 32'h000FF058;
   localparam logic [31:0] MEM_MAX_ADDR = 32'h000FFFFC;

   typedef enum logic {
      WB_IDLE = 1'b0,
      WB_ACK  = 1'b1
   } wb_state_t;

endpackage

// File: rtl/dbg_sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Push is ignored when full, pop is ignored when empty.
module dbg_sync_fifo #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 8,
   parameter int PTR_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     head_data,
   output logic                 full,
   output logic                 empty,
   output logic [PTR_WIDTH:0]   count
);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH:0]   count_q;
   logic                 do_push;
   logic                 do_pop;

   assign full      = (count_q == (PTR_WIDTH+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_data = mem[rd_ptr];
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;

   // Pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; contents are meaningless once pointers reset
   always_ff @(posedge clk) begin
      if (rst && do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/trace_packet_queue.sv
// Ready queue of trace packet start addresses between the DMA
// and the debug CPU, exposed through a Wishbone register file.
module trace_packet_queue #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DEPTH         = 8,
   parameter int PTR_WIDTH     = 3,
   parameter logic [ADDRESS_WIDTH-1:0] MEM_MIN_ADDR =
      ADDRESS_WIDTH'(dbg_dma_pkg::MEM_MIN_ADDR)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fifo_store_packet,
   input  logic [ADDRESS_WIDTH-1:0] initial_trace_address,
   output logic                     address_ack,
   output logic [ADDRESS_WIDTH-1:0] last_address_read,
   input  logic [3:0]               wbs_adr_i,
   input  logic [ADDRESS_WIDTH-1:0] wbs_dat_i,
   output logic [ADDRESS_WIDTH-1:0] wbs_dat_o,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_we_i,
   output logic                     wbs_ack_o,
   output logic                     irq_o
);

   import dbg_dma_pkg::*;

   wb_state_t                state_q;
   wb_state_t                state_d;
   logic                     access;
   logic                     push_fire;
   logic                     pop_fire;
   logic                     rel_wr;
   logic [ADDRESS_WIDTH-1:0] head_data;
   logic                     full;
   logic                     empty;
   logic [PTR_WIDTH:0]       count;
   logic [ADDRESS_WIDTH-1:0] status_word;
   logic [ADDRESS_WIDTH-1:0] rd_data;
   logic                     unused_low_bits;

   // Release pointer is word aligned, so the low data bits are dropped
   assign unused_low_bits = ^wbs_dat_i[1:0];

   // Ack gate keeps a still-held request from pushing twice
   assign push_fire = fifo_store_packet & ~full & ~address_ack;
   assign pop_fire  = access & ~wbs_we_i & (wbs_adr_i == REG_POP) & ~empty;
   assign rel_wr    = access & wbs_we_i & (wbs_adr_i == REG_RELEASE);
   assign irq_o     = ~empty;

   dbg_sync_fifo #(
      .WIDTH     (ADDRESS_WIDTH),
      .DEPTH     (DEPTH),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_fire),
      .push_data (initial_trace_address),
      .pop       (pop_fire),
      .head_data (head_data),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   // Wishbone slave state register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= WB_IDLE;
      else      state_q <= state_d;
   end

   // Wishbone next state: one access cycle then one ack cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         WB_IDLE: if (wbs_cyc_i && wbs_stb_i) state_d = WB_ACK;
         WB_ACK:  state_d = WB_IDLE;
         default: state_d = WB_IDLE;
      endcase
   end

   // Wishbone outputs decoded from state
   always_comb begin
      access    = (state_q == WB_IDLE) & wbs_cyc_i & wbs_stb_i;
      wbs_ack_o = (state_q == WB_ACK);
   end

   // STATUS layout: not_empty, full, count
   always_comb begin
      status_word                = '0;
      status_word[0]             = ~empty;
      status_word[1]             = full;
      status_word[PTR_WIDTH+2:2] = count;
   end

   // Read mux; empty FIFO reads back as zero
   always_comb begin
      rd_data = '0;
      case (wbs_adr_i)
         REG_STATUS:  rd_data = status_word;
         REG_HEAD:    rd_data = empty ? '0 : head_data;
         REG_POP:     rd_data = empty ? '0 : head_data;
         REG_RELEASE: rd_data = last_address_read;
         default:     rd_data = '0;
      endcase
   end

   // Registered ack to the DMA, read data and release pointer
   always_ff @(posedge clk) begin
      if (!rst) begin
         address_ack       <= 1'b0;
         wbs_dat_o         <= '0;
         last_address_read <= MEM_MIN_ADDR;
      end else begin
         address_ack <= push_fire;
         if (access) wbs_dat_o <= wbs_we_i ? '0 : rd_data;
         if (rel_wr) last_address_read <= {wbs_dat_i[ADDRESS_WIDTH-1:2], 2'b00};
      end
   end

endmodule

// File: doc/trace_packet_queue.md
Name: trace_packet_queue

Overview:
- Ready queue directly downstream of the debug co-processor DMA.
- Accepts the start address of each trace packet the DMA has finished writing to the RAM ring, and buffers it in a FIFO.
- Exposes the FIFO to the debug CPU through a Wishbone slave register file.
- Returns the CPU's release pointer to the DMA as last_address_read, so the DMA knows how much of the ring it may overwrite.

Parameters:
- ADDRESS_WIDTH, 32: width of trace addresses and the Wishbone data bus.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- PTR_WIDTH, 3: log2(DEPTH).
- MEM_MIN_ADDR, 32'h000FF058: low end of the DMA ring; reset value of last_address_read.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-low: 0 resets on the next rising clk edge.
- fifo_store_packet  in  1  DMA push request; held high until address_ack is seen.
- initial_trace_address  in  ADDRESS_WIDTH  packet start address; valid while fifo_store_packet is high.
- address_ack  out  1  one-cycle pulse: entry accepted.
- last_address_read  out  ADDRESS_WIDTH  CPU release pointer to the DMA.
- wbs_adr_i  in  4  byte offset of the register.
- wbs_dat_i  in  ADDRESS_WIDTH  write data.
- wbs_dat_o  out  ADDRESS_WIDTH  read data.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_ack_o  out  1  Wishbone acknowledge.
- irq_o  out  1  high while the FIFO is not empty.

Behaviour:
- Reset values (rst=0 at an edge):
  - FIFO empty; rd_ptr=wr_ptr=count=0.
  - address_ack=0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
  - last_address_read=MEM_MIN_ADDR.
  - Reset mid-transfer discards all entries and any pending Wishbone access.
- Push handshake (DMA side):
  - At an edge where fifo_store_packet=1, full=0 and address_ack=0: write initial_trace_address to mem[wr_ptr], increment wr_ptr (wraps at DEPTH), and register address_ack=1 for exactly one cycle.
  - address_ack is always registered. The "address_ack=0" term stops a double push while the DMA still holds the request in the ack cycle.
  - While full: address_ack stays 0 and the request is held off indefinitely, with no drop and no overwrite.
- Wishbone slave, two states:
  - IDLE: on cyc&stb, perform the access and go to ACK.
  - ACK: wbs_ack_o=1 for one cycle, then return to IDLE.
  - Every access takes 2 cycles. Read data is registered and valid in the ACK cycle.
- Register map:
  - 0x0 STATUS (RO): bit0 = not_empty, bit1 = full, bits[PTR_WIDTH+2:2] = count (0..DEPTH); all other bits 0.
  - 0x4 HEAD (RO): returns mem[rd_ptr] without popping; returns 0 when empty.
  - 0x8 POP (RO): returns mem[rd_ptr] and increments rd_ptr at the IDLE->ACK edge. When empty it returns 0 and does not pop, so no underflow.
  - 0xC RELEASE (RW): a write sets last_address_read = wbs_dat_i with bits[1:0] cleared; a read returns last_address_read.
  - Writes to RO offsets and accesses to unmapped offsets are acknowledged, return 0 and have no effect.
- Counting:
  - count is PTR_WIDTH+1 bits wide.
  - full = (count==DEPTH); empty = (count==0). Both are decoded from the registered count, before the edge.
  - Push and pop at the same edge: both take effect and count is unchanged.
  - A pop while full frees space only after that edge. A pending push is accepted one cycle later.
- irq_o = registered not_empty. It deasserts the cycle after the pop that empties the FIFO.
- Ordering is strict FIFO. There is no reordering and last_address_read is not checked: the CPU is responsible for monotonic releases.

Decomposition:
- Package dbg_dma_pkg:
  - register offsets REG_STATUS=4'h0, REG_HEAD=4'h4, REG_POP=4'h8, REG_RELEASE=4'hC;
  - MEM_MIN_ADDR and MEM_MAX_ADDR, shared with the DMA;
  - Wishbone slave state encoding.
- One natural sub-module: dbg_sync_fifo (parameterised DEPTH/width, push/pop/full/empty/count).
- The Wishbone decode and the push handshake stay in the top level.

Test Plan:
- Reset: rst=0 for 2 cycles -> address_ack=0, wbs_ack_o=0, irq_o=0, last_address_read=32'h000FF058; STATUS read returns 0.
- Single push: fifo_store_packet=1 with address 32'h000FF058 held until ack -> address_ack high for exactly 1 cycle and exactly one entry pushed; irq_o=1; STATUS returns 32'h5 (count=1, not_empty); HEAD returns 32'h000FF058 and count is unchanged.
- Fill to DEPTH=8 with addresses 32'h000FF060 + 8*i, then hold a 9th request -> no ack while full. POP returns 32'h000FF060 and the 9th ack follows 1 cycle after the pop edge. Subsequent POPs return addresses in push order.
- Pop when empty: POP read -> data 0, count stays 0, no pointer change; irq_o stays 0.
- Simultaneous push and POP at count=3 -> count stays 3 and the popped value is the oldest entry.
- RELEASE: write 32'h000FF1A7 -> last_address_read=32'h000FF1A4 and a readback returns the same. A write to 0x4 is ignored, and a read of offset 0x2 returns 0 with an ack.
